// File: rtl/pattern_burst_writer_pkg.sv
// Shared encodings for the pattern burst writer: pattern modes, FSM states and
// the LFSR constants used by the word generator.
package pattern_burst_writer_pkg;

   typedef enum logic [1:0] {
      MODE_INCR  = 2'd0,
      MODE_CONST = 2'd1,
      MODE_WALK  = 2'd2,
      MODE_LFSR  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_WRITE,
      ST_DONE
   } state_e;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
   localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/pattern_burst_writer_if.sv
// Avalon-MM burst write bus between the pattern writer (master) and memory (slave).
interface pattern_burst_writer_if #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned BURST_WIDTH   = 4
);
   logic [ADDRESS_WIDTH-1:0]  master_address;
   logic                      master_write;
   logic [DATA_WIDTH-1:0]     master_writedata;
   logic [BURST_WIDTH-1:0]    master_burstcount;
   logic [DATA_WIDTH/8-1:0]   master_byteenable;
   logic                      master_waitrequest;

   modport master (
      output master_address,
      output master_write,
      output master_writedata,
      output master_burstcount,
      output master_byteenable,
      input  master_waitrequest
   );

   modport slave (
      input  master_address,
      input  master_write,
      input  master_writedata,
      input  master_burstcount,
      input  master_byteenable,
      output master_waitrequest
   );
endinterface

// File: rtl/pattern_word_gen.sv
// Test-pattern word source: word index and LFSR/constant register, restarted by
// load and stepped by advance; the output word is a pure function of that state.
module pattern_word_gen
   import pattern_burst_writer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  mode_e                 mode,
   input  logic [31:0]           seed,
   input  logic                  load,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] word
);
   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned LANES = DATA_WIDTH / 32;
   localparam int unsigned SHW   = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   // 8-bit index wraps cleanly for both INCR (mod 256) and WALK (mod DATA_WIDTH).
   logic [7:0]  idx_q, idx_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [7:0]  incr_base;

   always_comb begin
      idx_d  = idx_q;
      lfsr_d = lfsr_q;
      if (load) begin
         idx_d  = '0;
         lfsr_d = (mode == MODE_LFSR && seed == '0) ? LFSR_ZERO_SEED : seed;
      end else if (advance) begin
         idx_d = idx_q + 8'd1;
         if (mode == MODE_LFSR) lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q  <= '0;
         lfsr_q <= '0;
      end else begin
         idx_q  <= idx_d;
         lfsr_q <= lfsr_d;
      end
   end

   assign incr_base = 8'(32'(idx_q) * NB);

   always_comb begin
      word = '0;
      unique case (mode)
         MODE_INCR: begin
            for (int unsigned i = 0; i < NB; i++) begin
               word[8*i +: 8] = incr_base + 8'(NB - 1 - i);
            end
         end
         MODE_CONST, MODE_LFSR: word = {LANES{lfsr_q}};
         MODE_WALK:             word = ONE << idx_q[SHW-1:0];
      endcase
   end

endmodule

// File: rtl/pattern_burst_writer.sv
// Frame-oriented Avalon-MM burst writer: fills numbursts fixed-length bursts from
// a base address with a selectable test pattern, optionally repeating frames.
module pattern_burst_writer
   import pattern_burst_writer_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned BURST_COUNT   = 8,
   parameter int unsigned BURST_WIDTH   = 4,
   parameter int unsigned NBURST_WIDTH  = 16,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = ADDRESS_WIDTH'(32'h3800_0000)
) (
   input  logic                     clk,
   input  logic                     reset,
   pattern_burst_writer_if.master   bus,
   input  logic                     ctrl_start,
   input  logic                     ctrl_stop,
   input  logic                     ctrl_continuous,
   input  logic [1:0]               ctrl_mode,
   input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
   input  logic [NBURST_WIDTH-1:0]  ctrl_numbursts,
   input  logic [31:0]              ctrl_seed,
   output logic                     ctrl_busy,
   output logic                     ctrl_done,
   output logic [15:0]              ctrl_frames
);
   localparam int unsigned BURST_BYTES = BURST_COUNT * DATA_WIDTH / 8;
   localparam logic [BURST_WIDTH-1:0] LAST_BEAT = BURST_WIDTH'(BURST_COUNT - 1);

   state_e                    state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0]  base_q, base_d;
   mode_e                     mode_q, mode_d;
   logic [31:0]               seed_q, seed_d;
   logic [NBURST_WIDTH-1:0]   nbursts_q, nbursts_d;
   logic [NBURST_WIDTH-1:0]   bursts_q, bursts_d;
   logic [BURST_WIDTH-1:0]    beat_q, beat_d;
   logic                      cont_q, cont_d;
   logic                      write_q, write_d;
   logic                      busy_q, busy_d;
   logic                      stop_q, stop_d;
   logic [15:0]               frames_q, frames_d;

   logic                      stop_pend;
   logic                      gen_load, gen_adv;
   mode_e                     gen_mode;
   logic [31:0]               gen_seed;
   logic [DATA_WIDTH-1:0]     gen_word;

   assign stop_pend = stop_q | ctrl_stop;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      base_d    = base_q;
      mode_d    = mode_q;
      seed_d    = seed_q;
      nbursts_d = nbursts_q;
      bursts_d  = bursts_q;
      beat_d    = beat_q;
      cont_d    = cont_q;
      write_d   = write_q;
      busy_d    = busy_q;
      stop_d    = stop_q;
      frames_d  = frames_q;
      gen_load  = 1'b0;
      gen_adv   = 1'b0;
      gen_mode  = mode_q;
      gen_seed  = seed_q;

      unique case (state_q)
         ST_IDLE: begin
            // Generator is loaded from the live inputs in the same cycle they are latched.
            gen_mode = mode_e'(ctrl_mode);
            gen_seed = ctrl_seed;
            if (ctrl_start) begin
               mode_d    = mode_e'(ctrl_mode);
               seed_d    = ctrl_seed;
               base_d    = ctrl_baseaddress;
               addr_d    = ctrl_baseaddress;
               nbursts_d = ctrl_numbursts;
               bursts_d  = ctrl_numbursts;
               cont_d    = ctrl_continuous;
               beat_d    = '0;
               busy_d    = 1'b1;
               frames_d  = '0;
               stop_d    = ctrl_stop;
               gen_load  = 1'b1;
               state_d   = ST_ARM;
            end
         end
         ST_ARM: begin
            stop_d = stop_pend;
            if (bursts_q == '0) begin
               state_d = ST_DONE;
            end else begin
               write_d = 1'b1;
               beat_d  = '0;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            stop_d = stop_pend;
            if (write_q && !bus.master_waitrequest) begin
               gen_adv = 1'b1;
               beat_d  = beat_q + BURST_WIDTH'(1);
               if (beat_q == LAST_BEAT) begin
                  write_d  = 1'b0;
                  addr_d   = addr_q + ADDRESS_WIDTH'(BURST_BYTES);
                  bursts_d = bursts_q - NBURST_WIDTH'(1);
                  state_d  = (bursts_q != NBURST_WIDTH'(1) && !stop_pend) ? ST_ARM : ST_DONE;
               end
            end
         end
         ST_DONE: begin
            frames_d = frames_q + 16'd1;
            stop_d   = 1'b0;
            if (cont_q && !stop_pend) begin
               addr_d   = base_q;
               bursts_d = nbursts_q;
               gen_load = 1'b1;
               state_d  = ST_ARM;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= BASE_ADDRESS;
         base_q    <= BASE_ADDRESS;
         mode_q    <= MODE_INCR;
         seed_q    <= '0;
         nbursts_q <= '0;
         bursts_q  <= '0;
         beat_q    <= '0;
         cont_q    <= 1'b0;
         write_q   <= 1'b0;
         busy_q    <= 1'b0;
         stop_q    <= 1'b0;
         frames_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         base_q    <= base_d;
         mode_q    <= mode_d;
         seed_q    <= seed_d;
         nbursts_q <= nbursts_d;
         bursts_q  <= bursts_d;
         beat_q    <= beat_d;
         cont_q    <= cont_d;
         write_q   <= write_d;
         busy_q    <= busy_d;
         stop_q    <= stop_d;
         frames_q  <= frames_d;
      end
   end

   pattern_word_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_gen (
      .clk     (clk),
      .reset   (reset),
      .mode    (gen_mode),
      .seed    (gen_seed),
      .load    (gen_load),
      .advance (gen_adv),
      .word    (gen_word)
   );

   assign bus.master_address    = addr_q;
   assign bus.master_write      = write_q;
   assign bus.master_writedata  = write_q ? gen_word : '0;
   assign bus.master_burstcount = BURST_WIDTH'(BURST_COUNT);
   assign bus.master_byteenable = '1;

   assign ctrl_busy   = busy_q;
   assign ctrl_done   = (state_q == ST_DONE);
   assign ctrl_frames = frames_q;

endmodule
